piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out converter sitting directly upstream of the 4-bit SIPO stage; it produces the serial bit stream that the SIPO reassembles.
- Accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock.
- Marks the first bit of each frame so a downstream SIPO or checker can align words.
- Supports gap-free back-to-back frames.

Parameters:
- WIDTH, 4, word width in bits; legal range 2 to 32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  a parallel word is offered.
- load_ready  output  1  the block can accept a word this cycle.
- load_data  input  WIDTH  the offered word.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- ser_first  output  1  high on the first bit of each frame.
- done  output  1  one-cycle pulse on the last bit of each frame.

Behaviour:
- Reset:
  - Synchronous and active-high; only sampled at the clk rising edge.
  - Forces state to IDLE, shift register to 0 and bit count to 0.
  - Forces ser_out, ser_valid, ser_first and done to 0.
  - load_ready is gated to 0 while rst is high.
  - Asserting rst mid-frame aborts the frame; remaining bits are dropped with no done pulse.
  - First accept is possible in the cycle after rst deasserts.
- State machine (two states):
  - IDLE: load_ready = 1; ser_valid = 0.
  - SHIFT: a frame is in flight; ser_valid = 1.
  - Accept occurs when load_valid && load_ready at an edge: capture load_data into the shift register, set count = 0, go to SHIFT.
- Latency:
  - A word accepted at edge N produces bits in cycles N+1 through N+WIDTH.
  - ser_first = 1 in cycle N+1 only.
  - done = 1 in cycle N+WIDTH only, coincident with the last bit.
- Bit order:
  - MSB_FIRST=1: ser_out = sreg[WIDTH-1]; shift left each cycle, filling with 0.
  - MSB_FIRST=0: ser_out = sreg[0]; shift right each cycle, filling with 0.
- Counter:
  - Width is $clog2(WIDTH).
  - Increments each SHIFT cycle; "last" is count == WIDTH-1.
  - The counter never wraps within a frame.
- Back-to-back frames:
  - In the last SHIFT cycle, load_ready = 1.
  - If load_valid is high then, the new word is captured, count resets, and the block stays in SHIFT. The next frame's first bit follows with no idle gap.
  - If load_valid is low, the block returns to IDLE.
- Other boundary conditions:
  - load_valid during a non-last SHIFT cycle is ignored (load_ready = 0). The upstream must hold the word.
  - In IDLE, ser_out = 0.
  - load_data is sampled only at an accept edge.
- Output registration:
  - All outputs except load_ready are registered.
  - load_ready is combinational from state, count and rst.

Decomposition:
- Shared package shift_pkg holds:
  - State enum: IDLE, SHIFT.
  - Default-width constant: 4.
- One natural sub-module: bit_counter.
  - Parameterized modulo counter with clear, enable and a terminal-count flag.
  - Reusable by the SIPO stage for its frame-complete indication.

Test Plan:
1. Reset mid-frame:
   - Stimulus: accept 4'b1011, assert rst after the 2nd bit.
   - Response: next cycle ser_valid = 0, done never pulses, load_ready = 0 while rst is high, then 1 after release.
2. MSB-first basic frame:
   - Stimulus: WIDTH=4, MSB_FIRST=1; load 4'b1010 at edge N.
   - Response: ser_out = 1,0,1,0 in cycles N+1..N+4; ser_first = 1 at N+1; done = 1 at N+4; then IDLE.
3. LSB-first:
   - Stimulus: MSB_FIRST=0; load 4'b1100.
   - Response: ser_out = 0,0,1,1.
4. Back-to-back frames:
   - Stimulus: load_valid held high with 4'hA then 4'h5.
   - Response: 8 consecutive valid bits 1,0,1,0,0,1,0,1; ser_first at bits 1 and 5; done at bits 4 and 8; no gap cycle.
5. Ignored mid-frame request:
   - Stimulus: assert load_valid with 4'hF during bit 2 of a 4'h0 frame.
   - Response: load_ready = 0; the frame finishes as 0,0,0,0; 4'hF is accepted at the last bit and sent as 1,1,1,1.
6. End-to-end with the SIPO:
   - Stimulus: chain this block to the SIPO and send 4'h9, then 4'h6.
   - Response: the SIPO's q equals each word one cycle after that frame's done.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serializer/deserializer pair.
// Holds the frame FSM state type and the default word width.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo counter with synchronous clear, enable and a terminal-count flag.
// Shared by the serializer and the SIPO stage for frame position tracking.
module bit_counter #(
    parameter  int MODULUS = 4,
    localparam int CW      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    logic [CW-1:0] r_count;

    // Clear outranks enable so a new frame can restart the count mid-wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: accepts a word on valid/ready and emits
// it one bit per clock with first-bit and last-bit frame markers.
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    // done is registered, so it is armed one bit before the last one.
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_shift;
    logic             r_ser_valid;
    logic             r_ser_first;
    logic             r_done;
    logic [CW-1:0]    w_count;
    logic             w_tc;
    logic             w_last;
    logic             w_accept;

    bit_counter #(
        .MODULUS (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_en    (r_state == SHIFT),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    assign w_last     = (r_state == SHIFT) && w_tc;
    assign load_ready = !rst && ((r_state == IDLE) || w_last);
    assign w_accept   = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Zero fill means the register is empty once a frame drains, so ser_out idles low.
    assign w_sreg_shift = (MSB_FIRST != 0) ? {r_sreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, r_sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ser_valid <= (w_state_nxt == SHIFT);
            r_ser_first <= w_accept;
            r_done      <= (r_state == SHIFT) && (w_count == PRE_LAST);
            if (w_accept) begin
                r_sreg <= load_data;
            end else if (r_state == SHIFT) begin
                r_sreg <= w_sreg_shift;
            end
        end
    end

    assign ser_out   = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];
    assign ser_valid = r_ser_valid;
    assign ser_first = r_ser_first;
    assign done      = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic ready_m, out_m, valid_m, first_m, done_m;
    logic ready_l, out_l, valid_l, first_l, done_l;

    int checks = 0;
    int failures = 0;

    // Reference model state: current word, bit index, bits left including current.
    logic [W-1:0] m_word = '0;
    int           m_idx  = 0;
    int           m_rem  = 0;
    logic [W-1:0] asm_m  = '0;
    logic [W-1:0] asm_l  = '0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
        .load_data(load_data), .ser_out(out_m), .ser_valid(valid_m),
        .ser_first(first_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
        .load_data(load_data), .ser_out(out_l), .ser_valid(valid_l),
        .ser_first(first_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check ready, clock, check outputs.
    task automatic cycle(input logic r, input logic lv, input logic [W-1:0] d);
        logic exp_ready;
        logic bm, bl;
        rst = r;
        load_valid = lv;
        load_data = d;
        #1;
        exp_ready = !r && (m_rem <= 1);
        check("ready_msb", ready_m, exp_ready);
        check("ready_lsb", ready_l, exp_ready);
        @(posedge clk);
        if (r) begin
            m_rem = 0;
            m_idx = 0;
        end else if (lv && exp_ready) begin
            m_word = d;
            m_idx  = 0;
            m_rem  = W;
        end else if (m_rem > 0) begin
            m_idx++;
            m_rem--;
        end
        @(negedge clk);
        bm = (m_rem > 0) ? m_word[W-1-m_idx] : 1'b0;
        bl = (m_rem > 0) ? m_word[m_idx] : 1'b0;
        check("valid_msb", valid_m, m_rem > 0);
        check("valid_lsb", valid_l, m_rem > 0);
        check("bit_msb", out_m, bm);
        check("bit_lsb", out_l, bl);
        check("first_msb", first_m, (m_rem > 0) && (m_idx == 0));
        check("first_lsb", first_l, (m_rem > 0) && (m_idx == 0));
        check("done_msb", done_m, m_rem == 1);
        check("done_lsb", done_l, m_rem == 1);
        // Downstream word reassembly, as a 4-bit SIPO would see it.
        if (valid_m) asm_m = {asm_m[W-2:0], out_m};
        if (valid_l) asm_l = {out_l, asm_l[W-1:1]};
        if (m_rem == 1) begin
            check("sipo_msb", asm_m, m_word);
            check("sipo_lsb", asm_l, m_word);
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset held: ready low, outputs cleared.
        cycle(1'b1, 1'b1, 4'hF);
        cycle(1'b1, 1'b0, 4'h0);

        // Basic frame 4'b1010, then idle.
        cycle(1'b0, 1'b1, 4'hA);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'h0);

        // 4'b1100: LSB instance emits 0,0,1,1.
        cycle(1'b0, 1'b1, 4'hC);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);

        // Back-to-back A then 5 with valid held high.
        cycle(1'b0, 1'b1, 4'hA);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);

        // 4'hF offered mid-frame of 4'h0 and held until taken on the last bit.
        cycle(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);

        // 4'h9 then 4'h6 end to end.
        cycle(1'b0, 1'b1, 4'h9);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'h6);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);

        // Reset after the second bit of 4'b1011 aborts the frame.
        cycle(1'b0, 1'b1, 4'hB);
        cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
